// File: rtl/bpm_window_ctrl_if.sv
// Handshake bundle between the measurement-window controller and its user/pulse counter.
// master drives start/continuous/count_in; slave (the controller) drives the rest.
interface bpm_window_ctrl_if;
  logic       start;
  logic       continuous;
  logic [7:0] count_in;
  logic       cnt_en;
  logic       cnt_clr;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       busy;
  logic [7:0] sec_left;

  modport master (
    output start, continuous, count_in,
    input  cnt_en, cnt_clr, bpm, bpm_valid, busy, sec_left
  );

  modport slave (
    input  start, continuous, count_in,
    output cnt_en, cnt_clr, bpm, bpm_valid, busy, sec_left
  );
endinterface

// File: rtl/bpm_window_ctrl.sv
// Measurement-window controller: gates the pulse counter for WINDOW_S seconds and converts the count to BPM.
// Optional macro BPM_AVG_EN reports the running mean of the last four saturated results.
module bpm_window_ctrl #(
  parameter int unsigned CLK_HZ   = 100000000,
  parameter int unsigned WINDOW_S = 15
) (
  input  logic                clk,
  input  logic                rst,
  bpm_window_ctrl_if.slave    bus
);

  localparam int unsigned MULT = 60 / WINDOW_S;
  localparam int unsigned PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_GATE   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_CALC   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    cap_q, cap_d;
  logic [7:0]    bpm_q, bpm_new;
  logic          valid_q;
  logic          cnt_en_q;
  logic          cnt_clr_q;
  logic          busy_q;
  logic [7:0]    sec_left_q;
  logic [14:0]   prod;
  logic [7:0]    sat;
  logic          calc_go;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    cap_d   = cap_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        presc_d = '0;
        sec_d   = 8'(WINDOW_S);
        state_d = S_GATE;
      end
      S_GATE: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          sec_d   = sec_q - 8'd1;
          if (sec_q == 8'd1) state_d = S_SETTLE;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_SETTLE: begin
        cap_d   = bus.count_in;
        state_d = S_CALC;
      end
      S_CALC: begin
        state_d = bus.continuous ? S_CLEAR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result is computed on the SETTLE->CALC edge from the value being captured,
  // so bpm and bpm_valid appear together in the CALC cycle.
  assign calc_go = (state_q == S_SETTLE);
  assign prod    = {7'b0, cap_d} * 15'(MULT);
  assign sat     = (|prod[14:8]) ? 8'hFF : prod[7:0];

`ifdef BPM_AVG_EN
  logic [7:0] hist_q [4];
  logic       hist_init_q;
  logic [9:0] sum;

  always_comb begin
    if (!hist_init_q) sum = {sat, 2'b00};
    else sum = 10'(sat) + 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]);
    bpm_new = 8'(sum >> 2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) hist_q[i] <= '0;
      hist_init_q <= 1'b0;
    end else if (calc_go) begin
      hist_init_q <= 1'b1;
      if (!hist_init_q) begin
        for (int unsigned i = 0; i < 4; i++) hist_q[i] <= sat;
      end else begin
        hist_q[0] <= sat;
        for (int unsigned i = 1; i < 4; i++) hist_q[i] <= hist_q[i-1];
      end
    end
  end
`else
  assign bpm_new = sat;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      sec_q      <= '0;
      cap_q      <= '0;
      bpm_q      <= '0;
      valid_q    <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      sec_left_q <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      cap_q      <= cap_d;
      valid_q    <= calc_go;
      cnt_en_q   <= (state_d == S_GATE);
      cnt_clr_q  <= (state_d == S_CLEAR);
      busy_q     <= (state_d != S_IDLE);
      sec_left_q <= (state_d == S_GATE) ? sec_d : '0;
      if (calc_go) bpm_q <= bpm_new;
    end
  end

  assign bus.cnt_en    = cnt_en_q;
  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.bpm       = bpm_q;
  assign bus.bpm_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.sec_left  = sec_left_q;

endmodule

// File: tb/tb_bpm_window_ctrl.sv
// Randomized bench for bpm_window_ctrl: outputs compared every cycle against a timeline model
// that tracks cycles elapsed since start was sampled.
module tb_bpm_window_ctrl;

  localparam int CLK  = 10;
  localparam int WIN  = 15;
  localparam int MUL  = 60 / WIN;
  localparam int GLEN = WIN * CLK;
  localparam int NCYC = 6000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpm_window_ctrl_if ifc();

  bpm_window_ctrl #(.CLK_HZ(CLK), .WINDOW_S(WIN)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_cnt_en"},    32'(ifc.cnt_en),    0);
    check_eq({pfx, "_cnt_clr"},   32'(ifc.cnt_clr),   0);
    check_eq({pfx, "_bpm"},       32'(ifc.bpm),       0);
    check_eq({pfx, "_bpm_valid"}, 32'(ifc.bpm_valid), 0);
    check_eq({pfx, "_busy"},      32'(ifc.busy),      0);
    check_eq({pfx, "_sec_left"},  32'(ifc.sec_left),  0);
  endtask

  // Model state
  bit   active;
  int   t0;
  int   cap_m;
  int   bpm_m;
  int   res_q[$];
  int   forced[10] = '{18, 20, 22, 24, 70, 63, 25, 0, 255, 64};
  int   fidx;
  int   aborts;

  function automatic int model_result(input int cnt);
    int s;
    int sum;
    s = (cnt * MUL > 255) ? 255 : cnt * MUL;
`ifdef BPM_AVG_EN
    if (res_q.size() == 0) begin
      for (int i = 0; i < 4; i++) res_q.push_front(s);
    end else begin
      res_q.push_front(s);
      void'(res_q.pop_back());
    end
    sum = 0;
    foreach (res_q[i]) sum += res_q[i];
    return sum / 4;
`else
    sum = s;
    return sum;
`endif
  endfunction

  initial begin
    int r;
    int e_en, e_clr, e_val, e_busy, e_sec;
    bit cont;

    rst = 1'b0;
    ifc.start = 1'b0;
    ifc.continuous = 1'b0;
    ifc.count_in = '0;
    active = 1'b0; t0 = 0; cap_m = 0; bpm_m = 0; fidx = 0; aborts = 0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      r = c - t0;
      e_clr  = (active && r == 1) ? 1 : 0;
      e_en   = (active && r >= 2 && r <= GLEN + 1) ? 1 : 0;
      e_val  = (active && r == GLEN + 3) ? 1 : 0;
      e_busy = active ? 1 : 0;
      e_sec  = e_en ? WIN - (r - 2) / CLK : 0;
      if (e_val) bpm_m = model_result(cap_m);

      check_eq("cnt_clr",   32'(ifc.cnt_clr),   32'(e_clr));
      check_eq("cnt_en",    32'(ifc.cnt_en),    32'(e_en));
      check_eq("bpm_valid", 32'(ifc.bpm_valid), 32'(e_val));
      check_eq("busy",      32'(ifc.busy),      32'(e_busy));
      check_eq("sec_left",  32'(ifc.sec_left),  32'(e_sec));
      check_eq("bpm",       32'(ifc.bpm),       32'(bpm_m));

      if (c >= 4000 && active && r == 62 && aborts < 2) begin
        aborts++;
        #2 rst = 1'b0;
        #1 check_all_zero("abort");
        active = 1'b0;
        bpm_m = 0;
        res_q.delete();
        #2 rst = 1'b1;
        ifc.start = 1'b0;
        ifc.count_in = 8'($urandom);
        continue;
      end

      // Stimulus for this cycle
      if (c < 20)        ifc.start = 1'b0;
      else if (c < 2000) ifc.start = ($urandom_range(9) == 0);
      else if (c < 4000) ifc.start = ($urandom_range(1) == 0);
      else               ifc.start = ($urandom_range(5) == 0);
      if (c < 2000)      cont = 1'b0;
      else if (c < 4000) cont = 1'b1;
      else               cont = ($urandom_range(1) == 0);
      ifc.continuous = cont;
      if (active && r == GLEN + 2 && fidx < 10) begin
        ifc.count_in = 8'(forced[fidx]);
        fidx++;
      end else begin
        ifc.count_in = 8'($urandom);
      end

      // Model update for the coming edge
      if (active && r == GLEN + 2) cap_m = int'(ifc.count_in);
      if (active && r == GLEN + 3) begin
        if (cont) t0 = c;
        else active = 1'b0;
      end else if (!active && ifc.start) begin
        active = 1'b1;
        t0 = c;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bpm_window_ctrl.md
Name: bpm_window_ctrl

Overview:
Measurement-window controller and BPM converter that sits directly downstream of the heart-rate pulse counter. It drives the counter's enable and clear, and opens a gate of exactly WINDOW_S seconds. When the gate closes it samples the 8-bit count, scales it to beats per minute with saturation, and presents the result with a one-cycle valid strobe. It supports single-shot and continuous (back-to-back) measurement.

Parameters:
CLK_HZ, 100000000, clock cycles per second; drives the 1 s prescaler; must be >= 2
WINDOW_S, 15, gate length in seconds; must divide 60 exactly (1,2,3,4,5,6,10,12,15,20,30,60); MULT = 60/WINDOW_S

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  level; sampled in IDLE; 1 begins a measurement
continuous  in  1  level; sampled in CALC; 1 restarts immediately after a result
count_in  in  8  count value from the pulse counter's bin output
cnt_en  out  1  drives the counter's enable; high only in GATE
cnt_clr  out  1  active-high clear pulse to the counter's reset; high only in CLEAR
bpm  out  8  last result; held until the next result
bpm_valid  out  1  one-cycle strobe; marks a new bpm value
busy  out  1  high in every state except IDLE
sec_left  out  8  seconds remaining in the gate; 0 outside GATE

Behaviour:
- All outputs are registered. Reset (rst=0) acts immediately and asynchronously: state=IDLE, cnt_en=0, cnt_clr=0, bpm=0, bpm_valid=0, busy=0, sec_left=0, prescaler=0, captured count=0.
- FSM states: IDLE, CLEAR, GATE, SETTLE, CALC.
- IDLE -> CLEAR when start=1. Otherwise stay in IDLE.
- CLEAR (1 cycle):
  - cnt_clr=1.
  - Load sec_left=WINDOW_S and prescaler=0.
  - Next state is GATE.
- GATE:
  - cnt_en=1.
  - The prescaler counts 0..CLK_HZ-1. On wrap it returns to 0 and sec_left decrements.
  - Leave for SETTLE on the wrap where sec_left==1.
  - cnt_en is therefore high for exactly WINDOW_S*CLK_HZ cycles.
- SETTLE (1 cycle):
  - cnt_en=0.
  - The counter's last enabled increment is now visible on count_in.
  - Capture count_in into an internal register.
- CALC (1 cycle):
  - bpm = min(captured*MULT, 255). The product is 15 bits wide (8 + 7) before saturation.
  - bpm_valid=1.
  - Next state is CLEAR if continuous=1, otherwise IDLE.
- start has no effect while busy=1. start held high in IDLE starts one measurement. If start is still high on return to IDLE, a new measurement starts.
- A rising pulse edge that lands in the counter's synchroniser while cnt_en=0 is not counted. This is accepted behaviour.
- Reset mid-operation aborts the measurement. No bpm_valid is issued, and bpm returns to 0.
- Latency from start sampled high (cycle 0):
  - CLEAR at cycle 1.
  - GATE at cycles 2..WINDOW_S*CLK_HZ+1.
  - SETTLE, then bpm_valid high at cycle WINDOW_S*CLK_HZ+3.
- Continuous period: WINDOW_S*CLK_HZ+3 cycles between bpm_valid strobes.

Optional Feature:
BPM_AVG_EN
- Defined:
  - The block keeps a 4-entry history of saturated results.
  - Reported bpm = (sum of the 4 entries) >> 2, truncated. The sum is 10 bits wide.
  - The first result after reset preloads all 4 entries.
  - History resets to 0 on rst.
  - Latency is unchanged; the averaging is folded into CALC.
- Not defined: bpm is the instantaneous saturated result and there is no history storage.

Test Plan:
All scenarios use CLK_HZ=10, WINDOW_S=15, so MULT=4 and the gate is 150 cycles.
1. Hold rst=0, then release -> all outputs 0, busy=0, and cnt_en stays 0 with start=0.
2. Single shot: start for 1 cycle, count_in=18 at SETTLE:
   - cnt_clr is high in cycle 1.
   - cnt_en is high for exactly 150 cycles.
   - bpm_valid pulses in cycle 153 with bpm=72.
   - Afterwards busy=0, and bpm holds 72.
3. Saturation: count_in=70 -> bpm=255. count_in=63 -> bpm=252.
4. Continuous:
   - continuous=1 with count_in 20 then 25 -> bpm 80 then 100.
   - bpm_valid strobes are 153 cycles apart.
   - A single cnt_clr pulse occurs between the gates.
5. Abort: drive rst=0 at cycle 60 of GATE:
   - cnt_en=0 and bpm=0 within the same cycle, with no bpm_valid.
   - A start after release gives a full 150-cycle gate.
6. Busy and averaging:
   - start toggled during GATE -> no effect on timing.
   - With BPM_AVG_EN, results 72, 80, 88, 96 -> reported bpm 72, 74, 78, 84.
